// File: rtl/cond_pkg.sv
// Shared definitions for the condition evaluation slice.
// Condition codes, flag bit positions and decision FSM states.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/cond_decode.sv
// Combinational condition decoder: {N,Z,C,V} x code -> take.
// Kept standalone so predication logic can share it.
module cond_decode
  import cond_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] code_i,
  output logic       take_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    take_o = 1'b0;
    unique case (code_i)
      COND_EQ: take_o = z;
      COND_NE: take_o = !z;
      COND_CS: take_o = c;
      COND_CC: take_o = !c;
      COND_MI: take_o = n;
      COND_PL: take_o = !n;
      COND_VS: take_o = v;
      COND_VC: take_o = !v;
      COND_HI: take_o = c & !z;
      COND_LS: take_o = !c | z;
      COND_GE: take_o = (n == v);
      COND_LT: take_o = (n != v);
      COND_GT: take_o = !z & (n == v);
      COND_LE: take_o = z | (n != v);
      COND_AL: take_o = 1'b1;
      COND_NV: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// Flag holder and registered branch-condition evaluator.
// Optional shadow flag save/restore enabled by COND_SHADOW_EN.
module cond_eval_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_valid,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_v,
  output logic             flag_ready,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             take_valid,
  output logic             take,
  input  logic             take_ready,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] taken_cnt
`ifdef COND_SHADOW_EN
  ,
  input  logic             save_req,
  input  logic             restore_req
`endif
);

  state_e           state_q;
  logic             take_q;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dec_take;
  logic             accept;
  logic             deliver;

`ifdef COND_SHADOW_EN
  logic [3:0] shadow_q;
  logic [3:0] shadow_d;

  assign flag_ready = !restore_req;
`else
  assign flag_ready = 1'b1;
`endif

  // Queries see the post-update flags (forwarding)
  always_comb begin
    flags_d = flags_q;
    if (flag_valid && flag_ready)
      flags_d = {flag_n, flag_z, flag_c, flag_v};
`ifdef COND_SHADOW_EN
    shadow_d = shadow_q;
    if (restore_req)
      flags_d = shadow_q;
    else if (save_req)
      shadow_d = flags_d;
`endif
  end

  assign take_valid = (state_q == ST_HOLD);
  assign take       = take_q;
  assign flags_out  = flags_q;
  assign taken_cnt  = cnt_q;
  assign cond_ready = !take_valid | take_ready;
  assign accept     = cond_valid & cond_ready;
  assign deliver    = take_valid & take_ready;

  cond_decode u_dec (
    .flags_i (flags_d),
    .code_i  (cond_code),
    .take_o  (dec_take)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      take_q   <= 1'b0;
      flags_q  <= 4'h0;
      cnt_q    <= '0;
`ifdef COND_SHADOW_EN
      shadow_q <= 4'h0;
`endif
    end else begin
      flags_q <= flags_d;
`ifdef COND_SHADOW_EN
      shadow_q <= shadow_d;
`endif
      if (deliver && take_q)
        cnt_q <= cnt_q + CNT_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_HOLD;
            take_q  <= dec_take;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            take_q <= dec_take;
          end else if (take_ready) begin
            state_q <= ST_IDLE;
            take_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit (default and COND_SHADOW_EN).
// Vector table, exhaustive decode sweep, corner sequences, random traffic.
module tb_cond_eval_unit;

  logic       clk;
  logic       reset;
  logic       flag_valid;
  logic [3:0] fl;
  logic       flag_ready;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       take_valid;
  logic       take;
  logic       take_ready;
  logic [3:0] flags_out;
  logic [7:0] taken_cnt;
`ifdef COND_SHADOW_EN
  logic       save_req;
  logic       restore_req;
`endif

  int checks;
  int errors;

  logic [3:0] m_flags;
  logic [3:0] m_shadow;
  logic       m_valid;
  logic       m_take;
  logic [7:0] m_cnt;

  typedef struct packed {
    logic [3:0] f;
    logic [3:0] c;
    logic       e;
  } vec_t;

  vec_t tbl[12];

  cond_eval_unit #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .flag_valid (flag_valid),
    .flag_n     (fl[3]),
    .flag_z     (fl[2]),
    .flag_c     (fl[1]),
    .flag_v     (fl[0]),
    .flag_ready (flag_ready),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_ready (cond_ready),
    .take_valid (take_valid),
    .take       (take),
    .take_ready (take_ready),
    .flags_out  (flags_out),
    .taken_cnt  (taken_cnt)
`ifdef COND_SHADOW_EN
    ,
    .save_req   (save_req),
    .restore_req(restore_req)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Odd codes negate the even code below them; E/F are always/never.
  function automatic logic golden(input logic [3:0] f,
                                  input logic [3:0] c);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock: check ready outputs, advance model, check registered state.
  task automatic cyc();
    logic [3:0] nf;
    logic fr, cr, acc;
    #1;
    fr = 1'b1;
`ifdef COND_SHADOW_EN
    fr = !restore_req;
`endif
    cr = !m_valid || take_ready;
    chk("cond_ready", int'(cond_ready), int'(cr));
    chk("flag_ready", int'(flag_ready), int'(fr));
    if (reset) begin
      m_flags = 0; m_shadow = 0; m_valid = 0;
      m_take = 0; m_cnt = 0;
    end else begin
      nf = (flag_valid && fr) ? fl : m_flags;
`ifdef COND_SHADOW_EN
      if (restore_req) nf = m_shadow;
      else if (save_req) m_shadow = nf;
`endif
      acc = cond_valid && cr;
      if (m_valid && take_ready && m_take) m_cnt = m_cnt + 8'd1;
      if (acc) begin
        m_valid = 1'b1;
        m_take  = golden(nf, cond_code);
      end else if (take_ready) begin
        m_valid = 1'b0;
      end
      m_flags = nf;
    end
    @(posedge clk);
    #1;
    chk("take_valid", int'(take_valid), int'(m_valid));
    if (m_valid) chk("take", int'(take), int'(m_take));
    chk("flags_out", int'(flags_out), int'(m_flags));
    chk("taken_cnt", int'(taken_cnt), int'(m_cnt));
  endtask

  task automatic idle_in();
    flag_valid = 0; fl = 0; cond_valid = 0;
    cond_code = 0; take_ready = 1;
`ifdef COND_SHADOW_EN
    save_req = 0; restore_req = 0;
`endif
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_flags = 0; m_shadow = 0; m_valid = 0;
    m_take = 0; m_cnt = 0;
    reset = 1;
    idle_in();
    @(posedge clk); #1;
    cyc();
    chk("rst_take_valid", int'(take_valid), 0);
    chk("rst_take", int'(take), 0);
    chk("rst_flags", int'(flags_out), 0);
    chk("rst_cnt", int'(taken_cnt), 0);
    chk("rst_cond_ready", int'(cond_ready), 1);
    reset = 0;

    tbl[0]  = '{4'b0100, 4'h0, 1'b1};
    tbl[1]  = '{4'b0100, 4'h1, 1'b0};
    tbl[2]  = '{4'b1000, 4'hA, 1'b0};
    tbl[3]  = '{4'b1001, 4'hA, 1'b1};
    tbl[4]  = '{4'b0010, 4'h8, 1'b1};
    tbl[5]  = '{4'b0110, 4'h8, 1'b0};
    tbl[6]  = '{4'b0000, 4'hC, 1'b1};
    tbl[7]  = '{4'b1000, 4'hD, 1'b1};
    tbl[8]  = '{4'b0000, 4'hE, 1'b1};
    tbl[9]  = '{4'b1111, 4'hF, 1'b0};
    tbl[10] = '{4'b0001, 4'h6, 1'b1};
    tbl[11] = '{4'b0011, 4'h9, 1'b0};
    for (int i = 0; i < 12; i++) begin
      flag_valid = 1; fl = tbl[i].f;
      cond_valid = 1; cond_code = tbl[i].c;
      cyc();
      chk($sformatf("vec%0d", i), int'(take), int'(tbl[i].e));
    end

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        flag_valid = 1; fl = 4'(f);
        cond_valid = 1; cond_code = 4'(c);
        cyc();
      end
    end
    idle_in();
    cyc();

    // Forwarding: same-cycle update N=1,V=0 with LT
    flag_valid = 1; fl = 4'b1000;
    cond_valid = 1; cond_code = 4'hB;
    cyc();
    chk("fwd_lt", int'(take), 1);
    flag_valid = 0; fl = 4'b0000;
    cyc();
    chk("fwd_lt_next", int'(take), 1);
    idle_in();
    cyc();

    // Stall: take_ready low for three cycles
    do_reset();
    flag_valid = 1; fl = 4'b0100;
    cond_valid = 1; cond_code = 4'h0;
    take_ready = 0;
    cyc();
    flag_valid = 0;
    cond_code = 4'h1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_cond_ready", int'(cond_ready), 0);
      chk("stall_take", int'(take), 1);
      chk("stall_valid", int'(take_valid), 1);
    end
    take_ready = 1; cond_valid = 0;
    cyc();
    chk("stall_release_cnt", int'(taken_cnt), 1);

    // Counter wrap: 256 taken decisions
    do_reset();
    cond_valid = 1; cond_code = 4'hE;
    for (int i = 0; i < 256; i++) cyc();
    chk("cnt_255", int'(taken_cnt), 255);
    cond_valid = 0;
    cyc();
    chk("cnt_wrap", int'(taken_cnt), 0);

    // Reset while holding a decision
    flag_valid = 1; fl = 4'b1111;
    cond_valid = 1; cond_code = 4'hE;
    take_ready = 0;
    cyc();
    cyc();
    reset = 1;
    cyc();
    chk("hold_rst_valid", int'(take_valid), 0);
    chk("hold_rst_flags", int'(flags_out), 0);
    chk("hold_rst_cnt", int'(taken_cnt), 0);
    reset = 0;
    idle_in();
    cyc();

`ifdef COND_SHADOW_EN
    flag_valid = 1; fl = 4'b1001; save_req = 1;
    cyc();
    save_req = 0; fl = 4'b0110;
    cyc();
    chk("pre_restore", int'(flags_out), 6);
    fl = 4'b1111; restore_req = 1;
    cond_valid = 1; cond_code = 4'h4;
    #1;
    chk("restore_flag_ready", int'(flag_ready), 0);
    cyc();
    chk("restore_flags", int'(flags_out), 9);
    chk("restore_query", int'(take), 1);
    idle_in();
    cyc();
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      flag_valid = $urandom_range(0, 1) == 1;
      fl         = 4'($urandom_range(0, 15));
      cond_valid = $urandom_range(0, 3) != 0;
      cond_code  = 4'($urandom_range(0, 15));
      take_ready = $urandom_range(0, 9) < 7;
`ifdef COND_SHADOW_EN
      save_req    = $urandom_range(0, 5) == 0;
      restore_req = $urandom_range(0, 7) == 0;
`endif
      cyc();
    end
    reset = 0;
    idle_in();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
